// File: rtl/rv_pkg.sv
// ============================================================================
//  Module   : rv_pkg
//  Brief    : RV32I opcode classes, ALU codes and ID/EX record types
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // ADDI x0,x0,0 with the constant 2'b11 low bits stripped
    localparam logic [29:0] NOP_WORD = 30'h4;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC
    } inst_class_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] link_pc;
    } idex_t;

    function automatic inst_class_e classify(input logic [4:0] opc);
        inst_class_e cls;
        case (opc)
            OP_R:      cls = CLS_R;
            OP_I:      cls = CLS_I;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   cls = CLS_JALR;
            OP_LUI:    cls = CLS_LUI;
            OP_AUIPC:  cls = CLS_AUIPC;
            default:   cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    // alt is funct7[5]; it selects SUB only for register-register ops
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       alt,
                                              input logic       allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_hazard_unit.sv
// ============================================================================
//  Module   : id_hazard_unit
//  Brief    : Combinational load-use and branch-operand hazard detection
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_hazard_unit (
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       use_rs1_i,
    input  logic       use_rs2_i,
    input  logic       resolves_pc_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_reg_write_i,
    input  logic [4:0] ex_rd_i,
    input  logic       mem_is_load_i,
    input  logic [4:0] mem_rd_i,
    output logic       hz_o
);

    logic w_ex_match;
    logic w_mem_match;
    logic w_load_use;
    logic w_br_ex;
    logic w_br_mem;

    assign w_ex_match  = (ex_rd_i != 5'd0) &&
                         ((use_rs1_i && (ex_rd_i == rs1_i)) ||
                          (use_rs2_i && (ex_rd_i == rs2_i)));
    assign w_mem_match = (mem_rd_i != 5'd0) &&
                         ((use_rs1_i && (mem_rd_i == rs1_i)) ||
                          (use_rs2_i && (mem_rd_i == rs2_i)));

    // Branch/JALR compare in ID, so any in-flight producer must drain first
    assign w_load_use = ex_mem_read_i && w_ex_match;
    assign w_br_ex    = resolves_pc_i && ex_reg_write_i && w_ex_match;
    assign w_br_mem   = resolves_pc_i && mem_is_load_i && w_mem_match;

    assign hz_o = w_load_use || w_br_ex || w_br_mem;

endmodule

`default_nettype wire

// File: rtl/instruction_decode.sv
// ============================================================================
//  Module   : instruction_decode
//  Brief    : RV32I ID stage - decode, branch resolve, hazard hold, ID/EX regs
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_decode #(
    parameter int          ALU_OP_W = 4,
    parameter logic [29:0] NOP_WORD = rv_pkg::NOP_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                memory_stall,
    input  logic [29:0]         instr_in,
    input  logic [31:0]         pc_in,
    input  logic [31:0]         pred_pc_in,
    output logic [4:0]          rs1_addr,
    output logic [4:0]          rs2_addr,
    input  logic [31:0]         rs1_rdata,
    input  logic [31:0]         rs2_rdata,
    input  logic [4:0]          mem_rd,
    input  logic                mem_is_load,
    output logic                flush,
    output logic [31:0]         branchPC,
    output logic                PC_write,
    output logic [29:0]         IF_DWrite,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_mem_to_reg,
    output logic                ex_alu_src,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [4:0]          ex_rd,
    output logic [4:0]          ex_rs1,
    output logic [4:0]          ex_rs2,
    output logic [31:0]         ex_rs1_data,
    output logic [31:0]         ex_rs2_data,
    output logic [31:0]         ex_imm,
    output logic [31:0]         ex_link_pc
);

    import rv_pkg::*;

    inst_class_e w_class;
    ctrl_t       w_ctrl;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic [31:0] w_imm;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_taken;
    logic        w_hz;
    logic [2:0]  w_f3;
    idex_t       idex_d;
    idex_t       idex_q;

    assign w_class    = classify(instr_in[4:0]);
    assign w_f3       = instr_in[12:10];
    assign rs1_addr   = instr_in[17:13];
    assign rs2_addr   = instr_in[22:18];
    assign w_pc_plus4 = pc_in + 32'd4;

    always_comb begin
        w_ctrl    = '0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_imm     = '0;
        case (w_class)
            CLS_R: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = alu_decode(w_f3, instr_in[28], 1'b1);
                w_use_rs1        = 1'b1;
                w_use_rs2        = 1'b1;
            end
            CLS_I: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = alu_decode(w_f3, instr_in[28], 1'b0);
                w_use_rs1        = 1'b1;
                w_imm            = {{20{instr_in[29]}}, instr_in[29:18]};
            end
            CLS_LOAD: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.alu_op     = ALU_ADD;
                w_use_rs1         = 1'b1;
                w_imm             = {{20{instr_in[29]}}, instr_in[29:18]};
            end
            CLS_STORE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = ALU_ADD;
                w_use_rs1        = 1'b1;
                w_use_rs2        = 1'b1;
                w_imm            = {{20{instr_in[29]}}, instr_in[29:23], instr_in[9:5]};
            end
            CLS_BRANCH: begin
                w_ctrl.alu_op = ALU_SUB;
                w_use_rs1     = 1'b1;
                w_use_rs2     = 1'b1;
                w_imm         = {{19{instr_in[29]}}, instr_in[29], instr_in[5],
                                 instr_in[28:23], instr_in[9:6], 1'b0};
            end
            CLS_JAL: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALU_ADD;
                w_imm            = {{11{instr_in[29]}}, instr_in[29], instr_in[17:10],
                                    instr_in[18], instr_in[28:19], 1'b0};
            end
            CLS_JALR: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALU_ADD;
                w_use_rs1        = 1'b1;
                w_imm            = {{20{instr_in[29]}}, instr_in[29:18]};
            end
            CLS_LUI: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = ALU_PASSB;
                w_imm            = {instr_in[29:10], 12'b0};
            end
            CLS_AUIPC: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = ALU_ADD;
                w_imm            = {instr_in[29:10], 12'b0};
            end
            default: begin
                w_ctrl = '0;
            end
        endcase
        // The canonical NOP has no architectural effect; treat it as a bubble
        if (instr_in == NOP_WORD) begin
            w_ctrl = '0;
        end
    end

    always_comb begin
        case (w_f3)
            3'b000:  w_taken = (rs1_rdata == rs2_rdata);
            3'b001:  w_taken = (rs1_rdata != rs2_rdata);
            3'b100:  w_taken = ($signed(rs1_rdata) <  $signed(rs2_rdata));
            3'b101:  w_taken = ($signed(rs1_rdata) >= $signed(rs2_rdata));
            3'b110:  w_taken = (rs1_rdata <  rs2_rdata);
            3'b111:  w_taken = (rs1_rdata >= rs2_rdata);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        case (w_class)
            CLS_BRANCH: w_next_pc = w_taken ? (pc_in + w_imm) : w_pc_plus4;
            CLS_JAL:    w_next_pc = pc_in + w_imm;
            CLS_JALR:   w_next_pc = (rs1_rdata + w_imm) & ~32'd1;
            default:    w_next_pc = w_pc_plus4;
        endcase
    end

    id_hazard_unit u_hazard (
        .rs1_i          (rs1_addr),
        .rs2_i          (rs2_addr),
        .use_rs1_i      (w_use_rs1),
        .use_rs2_i      (w_use_rs2),
        .resolves_pc_i  ((w_class == CLS_BRANCH) || (w_class == CLS_JALR)),
        .ex_mem_read_i  (idex_q.ctrl.mem_read),
        .ex_reg_write_i (idex_q.ctrl.reg_write),
        .ex_rd_i        (idex_q.rd),
        .mem_is_load_i  (mem_is_load),
        .mem_rd_i       (mem_rd),
        .hz_o           (w_hz)
    );

    assign PC_write  = w_hz & ~memory_stall;
    assign IF_DWrite = instr_in;
    assign flush     = ~w_hz & ~memory_stall & (w_next_pc != pred_pc_in);
    assign branchPC  = w_next_pc;

    always_comb begin
        idex_d          = '0;
        idex_d.ctrl     = w_ctrl;
        idex_d.rd       = w_ctrl.reg_write ? instr_in[9:5] : 5'd0;
        idex_d.rs1      = rs1_addr;
        idex_d.rs2      = rs2_addr;
        idex_d.rs1_data = rs1_rdata;
        idex_d.rs2_data = rs2_rdata;
        idex_d.imm      = w_imm;
        idex_d.link_pc  = w_pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else if (memory_stall) begin
            idex_q <= idex_q;
        end else if (w_hz) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ex_reg_write  = idex_q.ctrl.reg_write;
    assign ex_mem_read   = idex_q.ctrl.mem_read;
    assign ex_mem_write  = idex_q.ctrl.mem_write;
    assign ex_mem_to_reg = idex_q.ctrl.mem_to_reg;
    assign ex_alu_src    = idex_q.ctrl.alu_src;
    assign ex_alu_op     = ALU_OP_W'(idex_q.ctrl.alu_op);
    assign ex_rd         = idex_q.rd;
    assign ex_rs1        = idex_q.rs1;
    assign ex_rs2        = idex_q.rs2;
    assign ex_rs1_data   = idex_q.rs1_data;
    assign ex_rs2_data   = idex_q.rs2_data;
    assign ex_imm        = idex_q.imm;
    assign ex_link_pc    = idex_q.link_pc;

endmodule

`default_nettype wire

// File: tb/tb_instruction_decode.sv
// ============================================================================
//  Module   : tb_instruction_decode
//  Brief    : Directed self-checking bench for the ID stage
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_decode;

    localparam logic [4:0] C_OP_R      = 5'b01100;
    localparam logic [4:0] C_OP_LOAD   = 5'b00000;
    localparam logic [4:0] C_OP_BRANCH = 5'b11000;
    localparam logic [4:0] C_OP_JAL    = 5'b11011;
    localparam logic [4:0] C_OP_JALR   = 5'b11001;
    localparam logic [29:0] C_NOP      = 30'h4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memory_stall = 1'b0;
    logic [29:0] instr_in = 30'h4;
    logic [31:0] pc_in = '0;
    logic [31:0] pred_pc_in = 32'd4;
    logic [31:0] rs1_rdata = '0;
    logic [31:0] rs2_rdata = '0;
    logic [4:0]  mem_rd = '0;
    logic        mem_is_load = 1'b0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        flush, PC_write;
    logic [31:0] branchPC;
    logic [29:0] IF_DWrite;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_link_pc;

    int checks = 0;
    int errors = 0;

    instruction_decode dut (
        .clk(clk), .rst_n(rst_n), .memory_stall(memory_stall),
        .instr_in(instr_in), .pc_in(pc_in), .pred_pc_in(pred_pc_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
        .mem_rd(mem_rd), .mem_is_load(mem_is_load),
        .flush(flush), .branchPC(branchPC), .PC_write(PC_write), .IF_DWrite(IF_DWrite),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_link_pc(ex_link_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [29:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [29:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], C_OP_BRANCH};
    endfunction

    function automatic logic [29:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, C_OP_JAL};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [29:0] w, input logic [31:0] pc, input logic [31:0] pred);
        instr_in   = w;
        pc_in      = pc;
        pred_pc_in = pred;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got %0h exp 0", ex_reg_write); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0h exp 0", ex_rd); end
        checks++; if (ex_link_pc !== 32'd0) begin errors++; $display("FAIL reset_link_pc got %0h exp 0", ex_link_pc); end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        rs1_rdata = 32'd5;
        rs2_rdata = 32'd7;
        present(enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, C_OP_R), 32'h10, 32'h14);
        checks++; if (rs1_addr !== 5'd1) begin errors++; $display("FAIL add_rs1_addr got %0h exp 1", rs1_addr); end
        checks++; if (rs2_addr !== 5'd2) begin errors++; $display("FAIL add_rs2_addr got %0h exp 2", rs2_addr); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL add_flush got %0h exp 0", flush); end
        step();
        checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL add_reg_write got %0h exp 1", ex_reg_write); end
        checks++; if (ex_rd !== 5'd3) begin errors++; $display("FAIL add_rd got %0h exp 3", ex_rd); end
        checks++; if (ex_rs1_data !== 32'd5) begin errors++; $display("FAIL add_rs1_data got %0h exp 5", ex_rs1_data); end
        checks++; if (ex_rs2_data !== 32'd7) begin errors++; $display("FAIL add_rs2_data got %0h exp 7", ex_rs2_data); end
        checks++; if (ex_alu_op !== 4'd0) begin errors++; $display("FAIL add_alu_op got %0h exp 0", ex_alu_op); end
        checks++; if (ex_link_pc !== 32'h14) begin errors++; $display("FAIL add_link_pc got %0h exp 14", ex_link_pc); end
    endtask

    task automatic test_load_use();
        logic [29:0] add_w;
        add_w = enc_r(7'd0, 5'd5, 5'd5, 3'd0, 5'd6, C_OP_R);
        present(enc_i(12'd0, 5'd1, 3'b010, 5'd5, C_OP_LOAD), 32'h20, 32'h24);
        checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL lw_pc_write got %0h exp 0", PC_write); end
        step();
        checks++; if (ex_mem_read !== 1'b1) begin errors++; $display("FAIL lw_mem_read got %0h exp 1", ex_mem_read); end
        checks++; if (ex_mem_to_reg !== 1'b1) begin errors++; $display("FAIL lw_mem_to_reg got %0h exp 1", ex_mem_to_reg); end
        checks++; if (ex_alu_src !== 1'b1) begin errors++; $display("FAIL lw_alu_src got %0h exp 1", ex_alu_src); end
        checks++; if (ex_rd !== 5'd5) begin errors++; $display("FAIL lw_rd got %0h exp 5", ex_rd); end
        present(add_w, 32'h24, 32'h28);
        checks++; if (PC_write !== 1'b1) begin errors++; $display("FAIL lu_hold got %0h exp 1", PC_write); end
        checks++; if (IF_DWrite !== add_w) begin errors++; $display("FAIL lu_if_dwrite got %0h exp %0h", IF_DWrite, add_w); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL lu_flush got %0h exp 0", flush); end
        step();
        mem_rd      = 5'd5;
        mem_is_load = 1'b1;
        #1;
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL lu_bubble_rw got %0h exp 0", ex_reg_write); end
        checks++; if (ex_mem_read !== 1'b0) begin errors++; $display("FAIL lu_bubble_mr got %0h exp 0", ex_mem_read); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL lu_bubble_rd got %0h exp 0", ex_rd); end
        checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL lu_release got %0h exp 0", PC_write); end
        step();
        checks++; if (ex_rd !== 5'd6) begin errors++; $display("FAIL lu_issue_rd got %0h exp 6", ex_rd); end
        checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL lu_issue_rw got %0h exp 1", ex_reg_write); end
    endtask

    task automatic test_branch();
        mem_rd      = 5'd0;
        mem_is_load = 1'b0;
        rs1_rdata   = 32'd9;
        rs2_rdata   = 32'd8;
        present(enc_b(13'd16, 5'd2, 5'd1, 3'b000), 32'h40, 32'h44);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL beq_nt_flush got %0h exp 0", flush); end
        checks++; if (branchPC !== 32'h44) begin errors++; $display("FAIL beq_nt_pc got %0h exp 44", branchPC); end
        rs2_rdata = 32'd9;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL beq_t_flush got %0h exp 1", flush); end
        checks++; if (branchPC !== 32'h50) begin errors++; $display("FAIL beq_t_pc got %0h exp 50", branchPC); end
        checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL beq_pc_write got %0h exp 0", PC_write); end
        memory_stall = 1'b1;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL beq_stall_flush got %0h exp 0", flush); end
        memory_stall = 1'b0;
        step();
        checks++; if (ex_imm !== 32'h10) begin errors++; $display("FAIL beq_imm got %0h exp 10", ex_imm); end
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL beq_rw got %0h exp 0", ex_reg_write); end
        rs1_rdata = 32'hFFFF_FFFF;
        rs2_rdata = 32'd1;
        present(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b100), 32'h100, 32'h104);
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL blt_flush got %0h exp 1", flush); end
        checks++; if (branchPC !== 32'hF8) begin errors++; $display("FAIL blt_pc got %0h exp f8", branchPC); end
        present(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b110), 32'h100, 32'h104);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL bltu_flush got %0h exp 0", flush); end
        checks++; if (branchPC !== 32'h104) begin errors++; $display("FAIL bltu_pc got %0h exp 104", branchPC); end
        step();
    endtask

    task automatic test_jumps();
        rs1_rdata = 32'h101;
        present(enc_i(12'd8, 5'd2, 3'b000, 5'd1, C_OP_JALR), 32'h200, 32'h0);
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jalr_flush got %0h exp 1", flush); end
        checks++; if (branchPC !== 32'h108) begin errors++; $display("FAIL jalr_pc got %0h exp 108", branchPC); end
        step();
        checks++; if (ex_link_pc !== 32'h204) begin errors++; $display("FAIL jalr_link got %0h exp 204", ex_link_pc); end
        checks++; if (ex_rd !== 5'd1) begin errors++; $display("FAIL jalr_rd got %0h exp 1", ex_rd); end
        checks++; if (ex_imm !== 32'd8) begin errors++; $display("FAIL jalr_imm got %0h exp 8", ex_imm); end
        present(enc_j(21'h1FFFFC, 5'd0), 32'h300, 32'h2FC);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL jal_ok_flush got %0h exp 0", flush); end
        checks++; if (branchPC !== 32'h2FC) begin errors++; $display("FAIL jal_pc got %0h exp 2fc", branchPC); end
        pred_pc_in = 32'h304;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jal_mp_flush got %0h exp 1", flush); end
        step();
        checks++; if (ex_imm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jal_imm got %0h exp fffffffc", ex_imm); end
        checks++; if (ex_link_pc !== 32'h304) begin errors++; $display("FAIL jal_link got %0h exp 304", ex_link_pc); end
    endtask

    task automatic test_load_branch();
        present(enc_i(12'd0, 5'd3, 3'b010, 5'd4, C_OP_LOAD), 32'h400, 32'h404);
        step();
        rs1_rdata = 32'd0;
        rs2_rdata = 32'd0;
        present(enc_b(13'd8, 5'd0, 5'd4, 3'b000), 32'h404, 32'h408);
        checks++; if (PC_write !== 1'b1) begin errors++; $display("FAIL lb_hold1 got %0h exp 1", PC_write); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL lb_flush1 got %0h exp 0", flush); end
        step();
        mem_rd      = 5'd4;
        mem_is_load = 1'b1;
        #1;
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL lb_bubble got %0h exp 0", ex_reg_write); end
        checks++; if (PC_write !== 1'b1) begin errors++; $display("FAIL lb_hold2 got %0h exp 1", PC_write); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL lb_flush2 got %0h exp 0", flush); end
        step();
        mem_rd      = 5'd0;
        mem_is_load = 1'b0;
        #1;
        checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL lb_release got %0h exp 0", PC_write); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL lb_flush3 got %0h exp 1", flush); end
        checks++; if (branchPC !== 32'h40C) begin errors++; $display("FAIL lb_pc got %0h exp 40c", branchPC); end
        step();
        checks++; if (ex_imm !== 32'd8) begin errors++; $display("FAIL lb_imm got %0h exp 8", ex_imm); end
    endtask

    task automatic test_stall_reset();
        present(enc_i(12'd0, 5'd0, 3'b010, 5'd7, C_OP_LOAD), 32'h500, 32'h504);
        step();
        memory_stall = 1'b1;
        present(enc_r(7'd0, 5'd0, 5'd7, 3'd0, 5'd8, C_OP_R), 32'h504, 32'h0);
        checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL st_pc_write got %0h exp 0", PC_write); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL st_flush got %0h exp 0", flush); end
        step();
        checks++; if (ex_rd !== 5'd7) begin errors++; $display("FAIL st_hold_rd got %0h exp 7", ex_rd); end
        checks++; if (ex_mem_read !== 1'b1) begin errors++; $display("FAIL st_hold_mr got %0h exp 1", ex_mem_read); end
        checks++; if (ex_link_pc !== 32'h504) begin errors++; $display("FAIL st_hold_link got %0h exp 504", ex_link_pc); end
        memory_stall = 1'b0;
        #1;
        checks++; if (PC_write !== 1'b1) begin errors++; $display("FAIL st_resume got %0h exp 1", PC_write); end
        memory_stall = 1'b1;
        rst_n        = 1'b0;
        step();
        checks++; if (ex_mem_read !== 1'b0) begin errors++; $display("FAIL rst_mr got %0h exp 0", ex_mem_read); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL rst_rd got %0h exp 0", ex_rd); end
        checks++; if (ex_link_pc !== 32'd0) begin errors++; $display("FAIL rst_link got %0h exp 0", ex_link_pc); end
        checks++; if (ex_rs1 !== 5'd0) begin errors++; $display("FAIL rst_rs1 got %0h exp 0", ex_rs1); end
        rst_n        = 1'b1;
        memory_stall = 1'b0;
        present(C_NOP, 32'h600, 32'h604);
        step();
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL nop_rw got %0h exp 0", ex_reg_write); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_branch();
        test_jumps();
        test_load_branch();
        test_stall_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
